// File: rtl/quant_share_sched_if.sv
//==============================================================================
// Module      : quant_share_sched_if
// Description : Request, quantizer and output handshake bundle for quant_share_sched.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface quant_share_sched_if #(
    parameter int N_CH        = 4,
    parameter int NB_DATA_IN  = 50,
    parameter int NB_DATA_OUT = 16
);
    localparam int NB_CH = $clog2(N_CH);

    logic [N_CH-1:0]            i_valid;
    logic [N_CH*NB_DATA_IN-1:0] i_data;
    logic [N_CH-1:0]            o_ready;
    logic [NB_DATA_IN-1:0]      o_q_data;
    logic [NB_DATA_OUT-1:0]     i_q_data;
    logic                       i_q_sat;
    logic                       o_valid;
    logic                       i_ready;
    logic [NB_DATA_OUT-1:0]     o_data;
    logic [NB_CH-1:0]           o_ch;
    logic                       o_sat;

    modport slave (
        input  i_valid, i_data, i_q_data, i_q_sat, i_ready,
        output o_ready, o_q_data, o_valid, o_data, o_ch, o_sat
    );

    modport master (
        output i_valid, i_data, i_q_data, i_q_sat, i_ready,
        input  o_ready, o_q_data, o_valid, o_data, o_ch, o_sat
    );
endinterface

`default_nettype wire

// File: rtl/quant_share_sched.sv
//==============================================================================
// Module      : quant_share_sched
// Description : Round-robin time-sharing of one quantizer among N_CH channels.
//               SAT_CNT_EN builds the per-channel saturation event counters.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module quant_share_sched #(
    parameter int N_CH        = 4,
    parameter int NB_DATA_IN  = 50,
    parameter int NB_DATA_OUT = 16,
    parameter int NB_SATCNT   = 8
) (
    input  wire logic                    i_clk,
    input  wire logic                    i_rst,
    quant_share_sched_if.slave           bus,
    input  wire logic                    i_cnt_clr,
    input  wire logic [$clog2(N_CH)-1:0] i_cnt_sel,
    output logic      [NB_SATCNT-1:0]    o_sat_cnt
);

    localparam int               NB_CH     = $clog2(N_CH);
    localparam logic [NB_CH-1:0] c_LAST_CH = NB_CH'(N_CH - 1);

    logic                   r_s1_vld;
    logic [NB_DATA_IN-1:0]  r_s1_data;
    logic [NB_CH-1:0]       r_s1_ch;
    logic                   r_out_vld;
    logic [NB_DATA_OUT-1:0] r_out_data;
    logic [NB_CH-1:0]       r_out_ch;
    logic                   r_out_sat;
    logic [NB_CH-1:0]       r_rr_ptr;

    logic                   w_adv2;
    logic                   w_adv1;
    logic                   w_gnt_any;
    logic [NB_CH-1:0]       w_gnt_idx;
    logic [NB_CH-1:0]       w_scan_idx;
    logic [NB_DATA_IN-1:0]  w_gnt_data;
    int                     w_scan;

    assign w_adv2 = ~r_out_vld | bus.i_ready;
    assign w_adv1 = ~r_s1_vld | w_adv2;

    // First requester at or after the pointer wins; no grant while stalled or in reset.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan     = 0;
        w_scan_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= N_CH) begin
                w_scan = w_scan - N_CH;
            end
            w_scan_idx = NB_CH'(w_scan);
            if (!w_gnt_any && bus.i_valid[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
        if (i_rst || !w_adv1) begin
            w_gnt_any = 1'b0;
        end
    end

    assign w_gnt_data = bus.i_data[int'(w_gnt_idx) * NB_DATA_IN +: NB_DATA_IN];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_data  <= '0;
            r_s1_ch    <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_out_sat  <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_adv2) begin
                r_out_vld  <= r_s1_vld;
                r_out_data <= bus.i_q_data;
                r_out_sat  <= bus.i_q_sat & r_s1_vld;
                r_out_ch   <= r_s1_ch;
            end
            if (w_adv1) begin
                r_s1_vld <= w_gnt_any;
                if (w_gnt_any) begin
                    r_s1_data <= w_gnt_data;
                    r_s1_ch   <= w_gnt_idx;
                end
            end
            if (w_gnt_any) begin
                r_rr_ptr <= (w_gnt_idx == c_LAST_CH) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign bus.o_ready  = w_gnt_any ? (N_CH'(1) << w_gnt_idx) : '0;
    assign bus.o_q_data = r_s1_data;
    assign bus.o_valid  = r_out_vld;
    assign bus.o_data   = r_out_data;
    assign bus.o_ch     = r_out_ch;
    assign bus.o_sat    = r_out_sat;

`ifdef SAT_CNT_EN
    logic [NB_SATCNT-1:0] r_sat_cnt [N_CH];

    // Counting happens on the S2 load of a saturated word; clear takes priority.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            for (int c = 0; c < N_CH; c++) begin
                r_sat_cnt[c] <= '0;
            end
        end else if (w_adv2 && r_s1_vld && bus.i_q_sat && (r_sat_cnt[r_s1_ch] != '1)) begin
            r_sat_cnt[r_s1_ch] <= r_sat_cnt[r_s1_ch] + 1'b1;
        end
    end

    always_comb begin
        o_sat_cnt = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_cnt_sel == NB_CH'(c)) begin
                o_sat_cnt = r_sat_cnt[c];
            end
        end
    end
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^{i_cnt_clr, i_cnt_sel};
    assign o_sat_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_quant_share_sched.sv
//==============================================================================
// Module      : tb_quant_share_sched
// Description : Directed stimulus with a transaction-level scheduler model.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_quant_share_sched;
    localparam int N_CH        = 4;
    localparam int NB_DATA_IN  = 50;
    localparam int NB_DATA_OUT = 16;
    localparam int NB_SATCNT   = 8;
    localparam int CNT_MAX     = (1 << NB_SATCNT) - 1;
`ifdef SAT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cnt_clr = 1'b0;
    logic [1:0]           cnt_sel = '0;
    logic [NB_SATCNT-1:0] sat_cnt;

    quant_share_sched_if #(.N_CH(N_CH), .NB_DATA_IN(NB_DATA_IN), .NB_DATA_OUT(NB_DATA_OUT)) bus ();

    quant_share_sched #(
        .N_CH(N_CH), .NB_DATA_IN(NB_DATA_IN), .NB_DATA_OUT(NB_DATA_OUT), .NB_SATCNT(NB_SATCNT)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .i_cnt_clr (cnt_clr),
        .i_cnt_sel (cnt_sel),
        .o_sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    // Q5.45 -> Q1.15 with round-half-up and saturation
    function automatic logic [16:0] quant_model(input logic [49:0] x);
        longint v;
        v = longint'($signed(x));
        v = (v + 64'sd536870912) >>> 30;
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    always_comb begin
        {bus.i_q_sat, bus.i_q_data} = quant_model(bus.o_q_data);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        int          ch;
        bit          sat;
        int          acc;
        int          id;
    } exp_t;

    exp_t        mq[$];
    int          m_ptr = 0;
    int          m_cyc = 0;
    int          m_id = 0;
    int          m_shown = -1;
    int          m_cnt[N_CH];
    bit          m_clr_prev = 1'b0;
    logic [15:0] obs_d[$];
    int          obs_ch[$];
    bit          obs_sat[$];

    // Pipeline holds at most two words; a new one fits if one slot is free or one leaves.
    function automatic int model_grant();
        if (rst) return -1;
        if (!(mq.size() < 2 || bus.i_ready)) return -1;
        for (int k = 0; k < N_CH; k++) begin
            if (bus.i_valid[(m_ptr + k) % N_CH]) return (m_ptr + k) % N_CH;
        end
        return -1;
    endfunction

    initial begin
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        forever begin
            int          g;
            bit          vis;
            logic [3:0]  exp_rdy;
            logic [49:0] w;
            logic [16:0] qv;
            exp_t        e;
            @(negedge clk);
            vis = (mq.size() > 0) && (m_cyc >= mq[0].acc + 2);
            if (vis && mq[0].id != m_shown) begin
                m_shown = mq[0].id;
                if (mq[0].sat && !m_clr_prev && m_cnt[mq[0].ch] < CNT_MAX) m_cnt[mq[0].ch]++;
            end
            g = model_grant();
            exp_rdy = (g >= 0) ? (4'd1 << g) : 4'd0;
            check("o_ready", bus.o_ready, exp_rdy);
            check("o_valid", bus.o_valid, vis);
            if (vis) begin
                check("o_data", bus.o_data, mq[0].d);
                check("o_ch", bus.o_ch, mq[0].ch);
                check("o_sat", bus.o_sat, mq[0].sat);
            end
            check("o_sat_cnt", sat_cnt, CNT_ON ? m_cnt[cnt_sel] : 0);
            if (bus.o_valid && bus.i_ready && !rst) begin
                obs_d.push_back(bus.o_data);
                obs_ch.push_back(int'(bus.o_ch));
                obs_sat.push_back(bus.o_sat);
            end
            if (rst) begin
                mq.delete();
                m_ptr = 0;
                for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
                m_clr_prev = 1'b0;
            end else begin
                if (vis && bus.i_ready) void'(mq.pop_front());
                if (g >= 0) begin
                    w = bus.i_data[g*NB_DATA_IN +: NB_DATA_IN];
                    qv = quant_model(w);
                    e.d = qv[15:0]; e.sat = qv[16]; e.ch = g; e.acc = m_cyc; e.id = m_id;
                    mq.push_back(e);
                    m_id++;
                    m_ptr = (g + 1) % N_CH;
                end
                if (cnt_clr) for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
                m_clr_prev = cnt_clr;
            end
            m_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_word(input int ch, input logic [49:0] w);
        bus.i_data[ch*NB_DATA_IN +: NB_DATA_IN] = w;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.i_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_obs();
        obs_d.delete();
        obs_ch.delete();
        obs_sat.delete();
    endtask

    task automatic stream(input int ch, input logic [49:0] w0, input logic [49:0] step,
                          input int n, input int stall_at, input int stall_len);
        int          sent = 0;
        int          cyc = 0;
        logic [49:0] w = w0;
        logic [15:0] held = '0;
        while (sent < n && cyc < 2000) begin
            tick();
            bus.i_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            bus.i_valid = 4'd1 << ch;
            set_word(ch, w);
            @(negedge clk);
            if (cyc == stall_at) held = bus.o_data;
            if (stall_len >= 3 && cyc == stall_at + 2) begin
                check("bp_ready_low", bus.o_ready, 0);
                check("bp_data_hold", bus.o_data, held);
            end
            if (bus.o_ready[ch]) begin
                sent++;
                w = w + step;
            end
            cyc++;
        end
        if (sent < n) check("stream_timeout", sent, n);
        tick();
        bus.i_valid = '0;
        bus.i_ready = 1'b1;
    endtask

    task automatic run_valid(input logic [3:0] pat, input int ngnt,
                             output int got, output int onehot, output int cyc);
        got = 0; onehot = 0; cyc = 0;
        bus.i_valid = pat;
        while (got < ngnt && cyc < 100) begin
            @(negedge clk);
            if (bus.o_ready != 0) got++;
            if ($onehot(bus.o_ready)) onehot++;
            cyc++;
            tick();
        end
        bus.i_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int got, onehot, cyc;
        bus.i_valid = '0;
        bus.i_data  = '0;
        bus.i_ready = 1'b1;

        // Reset state and single word
        tick(); tick();
        @(negedge clk);
        check("rst_ready", bus.o_ready, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_ch", bus.o_ch, 0);
        check("rst_sat", bus.o_sat, 0);
        tick();
        rst = 1'b0;
        bus.i_valid = 4'b0100;
        set_word(2, 50'd1 << 44);
        @(negedge clk);
        check("single_grant", bus.o_ready, 4'b0100);
        tick();
        bus.i_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("single_valid", bus.o_valid, 1);
        check("single_data", bus.o_data, 16'h4000);
        check("single_ch", bus.o_ch, 2);
        check("single_sat", bus.o_sat, 0);

        // Round-robin fairness from a freshly reset pointer
        do_reset();
        clear_obs();
        for (int c = 0; c < N_CH; c++) set_word(c, 50'(c + 1) << 30);
        run_valid(4'hF, 8, got, onehot, cyc);
        repeat (4) tick();
        check("rr_cycles", cyc, 8);
        check("rr_onehot", onehot, 8);
        check("rr_count", obs_ch.size(), 8);
        for (int i = 0; i < obs_ch.size() && i < 8; i++) check("rr_tag", obs_ch[i], i % 4);

        // Sparse requests starting from pointer 2
        stream(1, 50'd1 << 30, 50'd0, 1, -10, 0);
        repeat (4) tick();
        clear_obs();
        set_word(1, 50'd1 << 30);
        set_word(3, 50'd3 << 30);
        run_valid(4'b1010, 4, got, onehot, cyc);
        repeat (4) tick();
        check("sparse_cycles", cyc, 4);
        check("sparse_count", obs_ch.size(), 4);
        for (int i = 0; i < obs_ch.size() && i < 4; i++) check("sparse_tag", obs_ch[i], (i % 2 == 0) ? 3 : 1);

        // Backpressure: 10 in, 10 out, in order
        clear_obs();
        stream(0, 50'd1 << 30, 50'd1 << 30, 10, 4, 3);
        repeat (5) tick();
        check("bp_count", obs_d.size(), 10);
        for (int i = 0; i < obs_d.size() && i < 10; i++) check("bp_data", obs_d[i], i + 1);

        // Saturation counting
        do_reset();
        clear_obs();
        cnt_sel = 2'd1;
        stream(1, 50'd1 << 46, 50'd0, 5, -10, 0);
        repeat (4) tick();
        check("sat_count_words", obs_d.size(), 5);
        for (int i = 0; i < obs_d.size() && i < 5; i++) begin
            check("sat_data", obs_d[i], 16'h7FFF);
            check("sat_flag", obs_sat[i], 1);
        end
        @(negedge clk);
        check("sat_cnt5", sat_cnt, CNT_ON ? 5 : 0);
        stream(1, 50'd1 << 46, 50'd0, 250, -10, 0);
        repeat (4) tick();
        @(negedge clk);
        check("sat_cnt255", sat_cnt, CNT_ON ? 255 : 0);
        stream(1, 50'd1 << 46, 50'd0, 1, -10, 0);
        repeat (4) tick();
        @(negedge clk);
        check("sat_cnt_hold", sat_cnt, CNT_ON ? 255 : 0);
        tick();
        bus.i_valid = 4'b0010;
        set_word(1, 50'd1 << 46);
        @(negedge clk);
        check("clr_grant", bus.o_ready, 4'b0010);
        tick();
        bus.i_valid = '0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_valid", bus.o_valid, 1);
        check("clr_sat", bus.o_sat, 1);
        check("clr_wins", sat_cnt, 0);

        // Reset with both stages occupied
        tick();
        bus.i_ready = 1'b0;
        bus.i_valid = 4'b0100;
        set_word(2, 50'd5 << 30);
        tick();
        tick();
        @(negedge clk);
        check("mid_full_valid", bus.o_valid, 1);
        check("mid_full_ready", bus.o_ready, 0);
        tick();
        rst = 1'b1;
        bus.i_valid = '0;
        tick();
        rst = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("mid_no_valid", bus.o_valid, 0);
        check("mid_data_clr", bus.o_data, 0);
        tick();
        bus.i_valid = 4'b1000;
        set_word(3, 50'd3 << 30);
        @(negedge clk);
        check("mid_grant3", bus.o_ready, 4'b1000);
        tick();
        bus.i_valid = '0;
        @(negedge clk);
        check("mid_lat1", bus.o_valid, 0);
        @(negedge clk);
        check("mid_lat2", bus.o_valid, 1);
        check("mid_ch", bus.o_ch, 3);
        check("mid_data", bus.o_data, 3);

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
